// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared widths, FSM encoding and the sign-magnitude helper for
//               the divider result BCD converter.
// Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int W          = 8;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = 3;

    // Counter value during the eighth and final double-dabble step.
    localparam logic [CNT_W-1:0] CONV_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // 0x80 maps to 128: the unsigned result is wide enough, so no overflow.
    function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dd_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dd_step
// Description : One combinational double-dabble step (add-3 then shift-left).
// Revision    : 1.0  initial release
// ============================================================================
module bcd_dd_step
    import div_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic [W-1:0]     mag_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic [W-1:0]     mag_o
);

    logic [BCD_W-1:0]   adj;
    logic [BCD_W+W-1:0] shifted;

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
        assign adj[4*d +: 4] = (bcd_i[4*d +: 4] >= 4'd5) ? (bcd_i[4*d +: 4] + 4'd3)
                                                         : bcd_i[4*d +: 4];
    end

    // BCD and magnitude shift as one register so the magnitude MSB enters the BCD LSB.
    assign shifted = {adj, mag_i} << 1;
    assign bcd_o   = shifted[BCD_W+W-1:W];
    assign mag_o   = shifted[W-1:0];

endmodule
`default_nettype wire

// File: rtl/div_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : div_bcd_conv
// Description : Converts a signed quotient/remainder pair into sign + 3-digit
//               BCD with an 8-step double-dabble FSM and valid/ready handshakes.
// Revision    : 1.0  initial release
// ============================================================================
module div_bcd_conv
    import div_pkg::*;
#(
    parameter int W = div_pkg::W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             q_sign,
    output logic [BCD_W-1:0] q_bcd,
    output logic             r_sign,
    output logic [BCD_W-1:0] r_bcd
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     q_mag_q, q_mag_d, r_mag_q, r_mag_d;
    logic [BCD_W-1:0] q_acc_q, q_acc_d, r_acc_q, r_acc_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             q_sign_q, q_sign_d, r_sign_q, r_sign_d;
    logic [BCD_W-1:0] q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;

    logic [BCD_W-1:0] q_acc_nx, r_acc_nx;
    logic [W-1:0]     q_mag_nx, r_mag_nx;

    bcd_dd_step u_q_step (
        .bcd_i (q_acc_q),
        .mag_i (q_mag_q),
        .bcd_o (q_acc_nx),
        .mag_o (q_mag_nx)
    );

    bcd_dd_step u_r_step (
        .bcd_i (r_acc_q),
        .mag_i (r_mag_q),
        .bcd_o (r_acc_nx),
        .mag_o (r_mag_nx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_mag_d   = q_mag_q;
        r_mag_d   = r_mag_q;
        q_acc_d   = q_acc_q;
        r_acc_d   = r_acc_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        q_sign_d  = q_sign_q;
        r_sign_d  = r_sign_q;
        q_bcd_d   = q_bcd_q;
        r_bcd_d   = r_bcd_q;
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    q_neg_d = q[W-1];
                    r_neg_d = r[W-1];
                    q_mag_d = mag_of(q);
                    r_mag_d = mag_of(r);
                    q_acc_d = '0;
                    r_acc_d = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                q_acc_d = q_acc_nx;
                r_acc_d = r_acc_nx;
                q_mag_d = q_mag_nx;
                r_mag_d = r_mag_nx;
                cnt_d   = cnt_q + 3'd1;
                // Output ports only change here, so they hold the previous result during CONV.
                if (cnt_q == CONV_LAST) begin
                    q_sign_d = q_neg_q;
                    r_sign_d = r_neg_q;
                    q_bcd_d  = q_acc_nx;
                    r_bcd_d  = r_acc_nx;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_mag_q  <= '0;
            r_mag_q  <= '0;
            q_acc_q  <= '0;
            r_acc_q  <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            q_bcd_q  <= '0;
            r_bcd_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_mag_q  <= q_mag_d;
            r_mag_q  <= r_mag_d;
            q_acc_q  <= q_acc_d;
            r_acc_q  <= r_acc_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
            q_bcd_q  <= q_bcd_d;
            r_bcd_q  <= r_bcd_d;
        end
    end

    assign q_sign = q_sign_q;
    assign r_sign = r_sign_q;
    assign q_bcd  = q_bcd_q;
    assign r_bcd  = r_bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_div_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_bcd_conv
// Description : Self-checking bench for div_bcd_conv against a decimal model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  q = 8'h00;
    logic [7:0]  r = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic        q_sign;
    logic        r_sign;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;

    int n_checks = 0;
    int n_pass   = 0;

    div_bcd_conv #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_sign    (q_sign),
        .q_bcd     (q_bcd),
        .r_sign    (r_sign),
        .r_bcd     (r_bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Decimal digits of the absolute value, straight from integer arithmetic.
    function automatic logic [11:0] ref_bcd(input logic [7:0] v);
        int m;
        m = v[7] ? (256 - int'(v)) : int'(v);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Transaction-level model: 0 = accepting, 1 = converting, 2 = presenting.
    bit          model_live = 1'b0;
    int          m_phase = 0;
    int          m_left = 0;
    logic [25:0] m_pending = '0;
    logic [25:0] m_last = '0;

    always @(posedge clk) begin
        if (rst) begin
            model_live <= 1'b1;
            m_phase    <= 0;
            m_last     <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pending <= {q[7], ref_bcd(q), r[7], ref_bcd(r)};
                    m_left    <= 8;
                    m_phase   <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_last  <= m_pending;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("in_ready", 32'(in_ready), 32'(m_phase == 0 && !rst));
            check("out_valid", 32'(out_valid), 32'(m_phase == 2));
            check("outputs", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'(m_last));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] qv, input logic [7:0] rv, input bit hold);
        bit hs;
        hs = 1'b0;
        q = qv;
        r = rv;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready;
            tick();
        end
        if (!hs) check("handshake_timeout", 32'd0, 32'd1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_result(input bit noise, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            if (noise) begin
                tick();
                q = 8'($urandom);
                r = 8'($urandom);
            end
        end
        if (lat == 0) check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_result(input int hold);
        tick();
        in_valid = 1'b0;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [7:0] v;
        logic [7:0] rv;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'd0);
        tick();

        send(8'h2A, 8'h04, 1'b0);
        wait_result(1'b0, lat);
        check("lat_2a", 32'(lat), 32'd9);
        check("pos_case", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'({1'b0, 12'h042, 1'b0, 12'h004}));
        release_result(0);

        send(8'h80, 8'hFF, 1'b0);
        wait_result(1'b0, lat);
        check("neg_extreme", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'({1'b1, 12'h128, 1'b1, 12'h001}));
        release_result(0);

        send(8'h7F, 8'h00, 1'b0);
        wait_result(1'b0, lat);
        check("pos_extreme", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'({1'b0, 12'h127, 1'b0, 12'h000}));
        release_result(0);

        // Backpressure: -100 and 49 held for 20 cycles.
        send(8'h9C, 8'h31, 1'b0);
        wait_result(1'b0, lat);
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            check("bp_hold", 32'({out_valid, in_ready, q_sign, q_bcd, r_sign, r_bcd}),
                  32'({1'b1, 1'b0, 1'b1, 12'h100, 1'b0, 12'h049}));
        end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_release", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
        tick();

        // in_valid stays high with changing data during conversion.
        send(8'hF5, 8'h03, 1'b1);
        wait_result(1'b1, lat);
        check("lat_ignored", 32'(lat), 32'd9);
        check("ignored_input", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'({1'b1, 12'h011, 1'b0, 12'h003}));
        release_result(0);

        // Reset lands on the fourth conversion step.
        send(8'h33, 8'h44, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
        check("midrst_outputs", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'd0);
        tick();
        send(8'h64, 8'h00, 1'b0);
        wait_result(1'b0, lat);
        check("after_rst", 32'({q_sign, q_bcd, r_sign, r_bcd}), 32'({1'b0, 12'h100, 1'b0, 12'h000}));
        release_result(0);

        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            for (int b = 0; b < 8; b++) rv[b] = v[7-b];
            send(v, rv, 1'b0);
            wait_result(1'b0, lat);
            check("latency", 32'(lat), 32'd9);
            release_result($urandom_range(0, 2));
        end

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(8'($urandom), 8'($urandom), 1'($urandom));
            wait_result(1'($urandom), lat);
            check("latency_rand", 32'(lat), 32'd9);
            release_result($urandom_range(0, 4));
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
